// File: rtl/positaccum_4_raw_prodsumsum.sv
// Sequential accumulator for raw ES2 products: sums each in_last-delimited group into
// one raw {sgn, scale, fraction, inf, zero} word with term count and sticky truncation.
module positaccum_4_raw_prodsumsum #(
    parameter int unsigned SCALE_W = 10,
    parameter int unsigned FRAC_W  = 130,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned W      = 1 + SCALE_W + FRAC_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_truncated,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_truncated,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned M_W = FRAC_W + 2;
    localparam int unsigned S_W = SCALE_W + 2;
    localparam int unsigned L_W = $clog2(FRAC_W + 2);
    localparam logic signed [S_W-1:0] SC_MAX = S_W'((1 << (SCALE_W - 1)) - 1);
    localparam logic signed [S_W-1:0] SC_MIN = S_W'(-(1 << (SCALE_W - 1)));

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t                    r_state;
    logic                      r_acc_sgn, r_acc_inf, r_acc_zero, r_acc_trunc;
    logic signed [SCALE_W-1:0] r_acc_scale;
    logic [FRAC_W-1:0]         r_acc_frac;
    logic [CNT_W-1:0]          r_acc_cnt;
    logic                      r_op_sgn, r_op_inf, r_op_zero, r_op_last;
    logic signed [SCALE_W-1:0] r_op_scale;
    logic [FRAC_W-1:0]         r_op_frac;
    logic [M_W-1:0]            r_mag_acc, r_mag_op, r_sum;
    logic signed [SCALE_W-1:0] r_scale;
    logic                      r_sum_sgn;
    logic                      r_in_ready, r_out_valid, r_out_trunc;
    logic [W-1:0]              r_out_data;
    logic [CNT_W-1:0]          r_out_count;

    logic [M_W-1:0]            w_mag_acc, w_mag_op, w_small, w_shifted;
    logic signed [S_W-1:0]     w_diff;
    logic [S_W-1:0]            w_dist;
    logic                      w_acc_big, w_bypass, w_align_lost;

    // Alignment: the smaller-scale magnitude is shifted onto the larger scale.
    always_comb begin
        w_mag_acc    = r_acc_zero ? '0 : {2'b01, r_acc_frac};
        w_mag_op     = r_op_zero ? '0 : {2'b01, r_op_frac};
        w_diff       = {{2{r_acc_scale[SCALE_W-1]}}, r_acc_scale}
                     - {{2{r_op_scale[SCALE_W-1]}}, r_op_scale};
        w_acc_big    = ~w_diff[S_W-1];
        w_dist       = w_acc_big ? $unsigned(w_diff) : $unsigned(-w_diff);
        w_bypass     = r_acc_zero | r_op_zero;
        w_small      = w_acc_big ? w_mag_op : w_mag_acc;
        w_shifted    = w_small >> w_dist;
        w_align_lost = ~w_bypass & (|(w_small & ~({M_W{1'b1}} << w_dist)));
    end

    logic [L_W-1:0]            w_lzc;
    logic [M_W-1:0]            w_norm;
    logic signed [S_W-1:0]     w_scale_ext, w_scale_new;
    logic signed [SCALE_W-1:0] w_scale_sat;
    logic [FRAC_W-1:0]         w_frac_new;
    logic                      w_carry, w_sum_zero, w_sat, w_norm_lost;
    logic                      w_new_sgn, w_new_inf, w_new_trunc;

    // Normalisation of the sum back to a hidden-bit form with saturating scale.
    always_comb begin
        w_lzc = '0;
        for (int unsigned i = 0; i <= FRAC_W; i++) begin
            if (r_sum[i]) w_lzc = L_W'(FRAC_W - i);
        end
        w_carry     = r_sum[M_W-1];
        w_sum_zero  = (r_sum == '0);
        w_norm      = r_sum << w_lzc;
        w_scale_ext = {{2{r_scale[SCALE_W-1]}}, r_scale};
        w_scale_new = w_carry ? w_scale_ext + S_W'(1)
                              : w_scale_ext - $signed(S_W'(w_lzc));
        w_frac_new  = w_carry ? r_sum[FRAC_W:1] : w_norm[FRAC_W-1:0];
        w_norm_lost = w_carry & r_sum[0];
        w_sat       = 1'b0;
        w_scale_sat = w_scale_new[SCALE_W-1:0];
        if (w_scale_new > SC_MAX) begin
            w_sat       = 1'b1;
            w_scale_sat = SC_MAX[SCALE_W-1:0];
        end else if (w_scale_new < SC_MIN) begin
            w_sat       = 1'b1;
            w_scale_sat = SC_MIN[SCALE_W-1:0];
        end
        if (w_sum_zero) begin
            w_frac_new  = '0;
            w_scale_sat = '0;
            w_sat       = 1'b0;
            w_norm_lost = 1'b0;
        end
        w_new_sgn   = ~w_sum_zero & r_sum_sgn;
        w_new_inf   = r_acc_inf | r_op_inf;
        w_new_trunc = r_acc_trunc | w_sat | w_norm_lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc_sgn   <= 1'b0;
            r_acc_scale <= '0;
            r_acc_frac  <= '0;
            r_acc_inf   <= 1'b0;
            r_acc_zero  <= 1'b1;
            r_acc_trunc <= 1'b0;
            r_acc_cnt   <= '0;
            r_op_sgn    <= 1'b0;
            r_op_scale  <= '0;
            r_op_frac   <= '0;
            r_op_inf    <= 1'b0;
            r_op_zero   <= 1'b1;
            r_op_last   <= 1'b0;
            r_mag_acc   <= '0;
            r_mag_op    <= '0;
            r_sum       <= '0;
            r_scale     <= '0;
            r_sum_sgn   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_trunc <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_sgn    <= in_data[W-1];
                        r_op_scale  <= in_data[W-2 -: SCALE_W];
                        r_op_frac   <= in_data[FRAC_W+1:2];
                        r_op_inf    <= in_data[1];
                        r_op_zero   <= in_data[0];
                        r_op_last   <= in_last;
                        r_acc_trunc <= r_acc_trunc | in_truncated;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_mag_acc   <= (w_bypass | w_acc_big) ? w_mag_acc : w_shifted;
                    r_mag_op    <= (w_bypass | ~w_acc_big) ? w_mag_op : w_shifted;
                    r_scale     <= w_bypass ? (r_acc_zero ? r_op_scale : r_acc_scale)
                                            : (w_acc_big ? r_acc_scale : r_op_scale);
                    r_acc_trunc <= r_acc_trunc | w_align_lost;
                    r_state     <= S_ADD;
                end
                S_ADD: begin
                    if (r_acc_sgn == r_op_sgn) begin
                        r_sum     <= r_mag_acc + r_mag_op;
                        r_sum_sgn <= r_acc_sgn;
                    end else if (r_mag_acc >= r_mag_op) begin
                        r_sum     <= r_mag_acc - r_mag_op;
                        r_sum_sgn <= r_acc_sgn;
                    end else begin
                        r_sum     <= r_mag_op - r_mag_acc;
                        r_sum_sgn <= r_op_sgn;
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_acc_sgn   <= w_new_sgn;
                    r_acc_scale <= w_scale_sat;
                    r_acc_frac  <= w_frac_new;
                    r_acc_inf   <= w_new_inf;
                    r_acc_zero  <= w_sum_zero;
                    r_acc_trunc <= w_new_trunc;
                    r_acc_cnt   <= r_acc_cnt + CNT_W'(1);
                    if (r_op_last) begin
                        r_out_data  <= {w_new_sgn, w_scale_sat, w_frac_new, w_new_inf,
                                        ~w_new_inf & w_sum_zero};
                        r_out_trunc <= w_new_trunc;
                        r_out_count <= r_acc_cnt + CNT_W'(1);
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc_sgn   <= 1'b0;
                        r_acc_scale <= '0;
                        r_acc_frac  <= '0;
                        r_acc_inf   <= 1'b0;
                        r_acc_zero  <= 1'b1;
                        r_acc_trunc <= 1'b0;
                        r_acc_cnt   <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_truncated = r_out_trunc;
    assign out_count     = r_out_count;

endmodule
